// File: rtl/spi_frame_slave_if.sv
// -----------------------------------------------------------------------------
// spi_frame_slave_if
// Bundles the SPI pins, the frame-publish strobe and the parallel frame
// data of the SPI frame slave.
//   slave modport  : sck, cs_b, sdo, latch, d, overrun_clr in;
//                    sdi, q, q_valid, frame_err, overrun out
//   master modport : the mirror image (PIC side / display logic side)
// FRAME_W must equal WORD_W*NWORDS of the attached spi_frame_slave.
// -----------------------------------------------------------------------------
interface spi_frame_slave_if #(
    parameter int FRAME_W = 64
);
    logic               sck;
    logic               cs_b;
    logic               sdo;
    logic               sdi;
    logic               latch;
    logic [FRAME_W-1:0] d;
    logic [FRAME_W-1:0] q;
    logic               q_valid;
    logic               frame_err;
    logic               overrun;
    logic               overrun_clr;

    modport slave (
        input  sck, cs_b, sdo, latch, d, overrun_clr,
        output sdi, q, q_valid, frame_err, overrun
    );

    modport master (
        output sck, cs_b, sdo, latch, d, overrun_clr,
        input  sdi, q, q_valid, frame_err, overrun
    );
endinterface

// File: rtl/spi_frame_slave.sv
// -----------------------------------------------------------------------------
// spi_frame_slave
// SPI slave that oversamples sck/cs_b/sdo/latch on the system clock, shifts a
// FRAME_W-bit frame in (sdo) and out (sdi) MSB first, double-buffers the
// received frame and publishes it on q only on a rising edge of latch.
// Ports:
//   clk    : system clock; sck must be at most clk/8
//   reset  : asynchronous, active-high reset
//   bus    : spi_frame_slave_if.slave
//            sck/cs_b/sdo/latch - asynchronous pins
//            d                  - transmit frame, captured at cs_b fall
//            sdi                - transmit data to PIC
//            q/q_valid          - published frame and one-cycle update pulse
//            frame_err          - one-cycle pulse on an aborted frame
//            overrun            - sticky, frame overwritten before publish
//            overrun_clr        - synchronous clear of overrun
// -----------------------------------------------------------------------------
module spi_frame_slave #(
    parameter int WORD_W      = 32,
    parameter int NWORDS      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_EDGE = 0
) (
    input  logic             clk,
    input  logic             reset,
    spi_frame_slave_if.slave bus
);
    localparam int FRAME_W = WORD_W * NWORDS;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Pin vector order: {latch, sdo, cs_b, sck}
    logic [3:0]                   pins_s;
    logic [SYNC_STAGES-1:0][3:0]  sync_q;
    logic [3:0]                   synced_s;
    logic [2:0]                   prev_q;   // {latch, cs_b, sck} one cycle late

    logic sck_s, cs_s, sdo_s, latch_s;
    logic sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s, latch_rise_s;
    logic sample_edge_s, drive_edge_s;
    logic publish_s, overrun_set_s;

    state_t             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [FRAME_W-1:0] tx_sr_q;
    logic [FRAME_W-1:0] rx_sr_q;
    logic [FRAME_W-1:0] rx_buf_q;
    logic               buf_full_q;
    logic               latch_rise_q;
    logic [FRAME_W-1:0] q_q;
    logic               q_valid_q;
    logic               frame_err_q;
    logic               overrun_q;
    logic               sdi_q;

    assign pins_s   = {bus.latch, bus.sdo, bus.cs_b, bus.sck};
    assign synced_s = sync_q[SYNC_STAGES-1];
    assign sck_s    = synced_s[0];
    assign cs_s     = synced_s[1];
    assign sdo_s    = synced_s[2];
    assign latch_s  = synced_s[3];

    assign sck_rise_s   = sck_s   & ~prev_q[0];
    assign sck_fall_s   = ~sck_s  &  prev_q[0];
    assign cs_rise_s    = cs_s    & ~prev_q[1];
    assign cs_fall_s    = ~cs_s   &  prev_q[1];
    assign latch_rise_s = latch_s & ~prev_q[2];

    assign sample_edge_s = (SAMPLE_EDGE == 0) ? sck_fall_s : sck_rise_s;
    assign drive_edge_s  = (SAMPLE_EDGE == 0) ? sck_rise_s : sck_fall_s;

    // A publish needs a registered latch edge and a full buffer; when it lands
    // in the DONE cycle the old frame is taken, so that case is not an overrun.
    assign publish_s     = latch_rise_q & buf_full_q;
    assign overrun_set_s = (state_q == ST_DONE) & buf_full_q & ~latch_rise_q;

    // Input synchronisers and the delayed copies used for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins_s};
            prev_q <= {latch_s, cs_s, sck_s};
        end
    end

    // Frame state machine, receive buffer, publish path and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            rx_buf_q     <= '0;
            buf_full_q   <= 1'b0;
            latch_rise_q <= 1'b0;
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            sdi_q        <= 1'b0;
        end else begin
            latch_rise_q <= latch_rise_s;
            q_valid_q    <= 1'b0;
            frame_err_q  <= 1'b0;

            if (publish_s) begin
                q_q        <= rx_buf_q;
                q_valid_q  <= 1'b1;
                buf_full_q <= 1'b0;
            end else begin
                q_q <= q_q;
            end

            // Set has priority over a coincident clear
            if (overrun_set_s) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        tx_sr_q   <= bus.d;
                        sdi_q     <= bus.d[FRAME_W-1];
                        bit_cnt_q <= '0;
                        rx_sr_q   <= '0;
                        state_q   <= ST_ACTIVE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (sample_edge_s) begin
                        rx_sr_q   <= {rx_sr_q[FRAME_W-2:0], sdo_s};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_ACTIVE;
                        end
                    end else if (cs_rise_s) begin
                        frame_err_q <= 1'b1;
                        rx_sr_q     <= '0;
                        state_q     <= ST_IDLE;
                    end else if (drive_edge_s && (bit_cnt_q != '0)) begin
                        // The first bit is already on sdi from the cs_b fall,
                        // so shifting starts only after the first sample.
                        tx_sr_q <= {tx_sr_q[FRAME_W-2:0], 1'b0};
                        sdi_q   <= tx_sr_q[FRAME_W-2];
                    end else begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_DONE: begin
                    rx_buf_q   <= rx_sr_q;
                    buf_full_q <= 1'b1;  // overrides a same-cycle publish clear
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q         = q_q;
    assign bus.q_valid   = q_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.sdi       = sdi_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_slave
// Directed bench for spi_frame_slave (WORD_W=32, NWORDS=2, SAMPLE_EDGE=0,
// sck = clk/10). A small buffer model pushes the expected published frame to a
// scoreboard queue when a latch is driven; a monitor pops it on q_valid.
// -----------------------------------------------------------------------------
module tb_spi_frame_slave;
    logic clk;
    logic reset;

    spi_frame_slave_if #(.FRAME_W(64)) bus();

    spi_frame_slave #(
        .WORD_W(32), .NWORDS(2), .SYNC_STAGES(2), .SAMPLE_EDGE(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int qv_cnt = 0;
    int fe_cnt = 0;
    int exp_qv = 0;
    int exp_fe = 0;

    logic [63:0] sb[$];
    logic [63:0] m_buf;
    logic        m_full;
    logic        exp_ovr;
    logic [63:0] exp_q;
    logic [63:0] pic_rx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: count pulses and score each published frame
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.q_valid === 1'b1) begin
                qv_cnt++;
                chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) chk("q_publish", bus.q, sb.pop_front());
            end
            if (bus.frame_err === 1'b1) fe_cnt++;
        end
    end

    // PIC side: drive sdo on rising sck, capture sdi on falling sck
    task automatic send(input logic [63:0] data, input logic [63:0] txd, input int nbits,
                        input bit raise_cs, input bit collide);
        bus.d = txd;
        pic_rx = 64'd0;
        bus.cs_b = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            bus.sdo = data[63-i];
            bus.sck = 1'b1;
            if (i == 10) bus.d = ~txd;  // must not disturb the frame in flight
            tick(5);
            pic_rx = {pic_rx[62:0], bus.sdi};
            bus.sck = 1'b0;
            if (collide && i == nbits - 1) bus.latch = 1'b1;
            tick(5);
        end
        tick(4);
        bus.latch = 1'b0;
        if (raise_cs) begin
            bus.cs_b = 1'b1;
            tick(8);
        end
    endtask

    task automatic frame_full(input logic [63:0] data, input logic [63:0] txd, input bit collide);
        if (collide) begin
            if (m_full) begin
                sb.push_back(m_buf);
                exp_q = m_buf;
                exp_qv++;
            end
        end else if (m_full) begin
            exp_ovr = 1'b1;
        end
        m_buf  = data;
        m_full = 1'b1;
        send(data, txd, 64, 1'b1, collide);
        chk("sdi_frame", pic_rx, txd);
        chk("overrun", {63'd0, bus.overrun}, {63'd0, exp_ovr});
    endtask

    task automatic do_latch();
        if (m_full) begin
            sb.push_back(m_buf);
            exp_q  = m_buf;
            exp_qv++;
            m_full = 1'b0;
        end
        bus.latch = 1'b1;
        tick(4);
        bus.latch = 1'b0;
        tick(8);
        chk("qv_count", 64'(qv_cnt), 64'(exp_qv));
        chk("q_value", bus.q, exp_q);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.sck = 1'b0; bus.cs_b = 1'b1; bus.sdo = 1'b0; bus.latch = 1'b0;
        bus.d = 64'd0; bus.overrun_clr = 1'b0;
        m_buf = 64'd0; m_full = 1'b0; exp_ovr = 1'b0; exp_q = 64'd0; pic_rx = 64'd0;
        tick(3);
        chk("rst_q", bus.q, 64'd0);
        chk("rst_q_valid", {63'd0, bus.q_valid}, 64'd0);
        chk("rst_frame_err", {63'd0, bus.frame_err}, 64'd0);
        chk("rst_overrun", {63'd0, bus.overrun}, 64'd0);
        chk("rst_sdi", {63'd0, bus.sdi}, 64'd0);
        reset = 1'b0;
        tick(6);

        // Basic frame in both directions
        frame_full(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
        do_latch();

        // Aborted frame: error pulse, no publish, then a good frame
        send(64'hCAFE_F00D_1234_5678, 64'h1111_2222_3333_4444, 40, 1'b1, 1'b0);
        exp_fe++;
        chk("frame_err_count", 64'(fe_cnt), 64'(exp_fe));
        do_latch();
        frame_full(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0);
        do_latch();

        // Overrun and its clear
        frame_full(64'hAAAA_AAAA_AAAA_AAAA, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        frame_full(64'h5555_5555_5555_5555, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
        do_latch();
        chk("overrun_held", {63'd0, bus.overrun}, 64'd1);
        bus.overrun_clr = 1'b1;
        tick(1);
        bus.overrun_clr = 1'b0;
        tick(2);
        exp_ovr = 1'b0;
        chk("overrun_cleared", {63'd0, bus.overrun}, 64'd0);

        // Two latches after one frame: one q_valid, q stable
        frame_full(64'h1357_9BDF_2468_ACE0, 64'hA5A5_5A5A_C3C3_3C3C, 1'b0);
        do_latch();
        do_latch();

        // DONE and latch edge in the same cycle
        frame_full(64'h0A0A_0A0A_B1B1_B1B1, 64'h7777_8888_9999_AAAA, 1'b0);
        frame_full(64'hB2B2_B2B2_C3C3_C3C3, 64'h1234_5678_9ABC_DEF0, 1'b1);
        chk("collide_q_old", bus.q, 64'h0A0A_0A0A_B1B1_B1B1);
        chk("collide_qv", 64'(qv_cnt), 64'(exp_qv));
        do_latch();
        chk("collide_q_new", bus.q, 64'hB2B2_B2B2_C3C3_C3C3);

        // Reset after 17 bits, then a clean frame
        send(64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("async_rst_q", bus.q, 64'd0);
        chk("async_rst_sdi", {63'd0, bus.sdi}, 64'd0);
        chk("async_rst_overrun", {63'd0, bus.overrun}, 64'd0);
        chk("async_rst_q_valid", {63'd0, bus.q_valid}, 64'd0);
        tick(2);
        reset = 1'b0;
        bus.cs_b = 1'b1;
        m_full = 1'b0; exp_ovr = 1'b0; exp_q = 64'd0;
        tick(8);
        frame_full(64'hDEAD_BEEF_0000_FFFF, 64'h0102_0304_0506_0708, 1'b0);
        do_latch();
        chk("no_err_after_reset", 64'(fe_cnt), 64'(exp_fe));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
